inv_butterfly: RTL
==================

INV_BUTTERFLY -- requirements
Module: inv_butterfly

Interface
REQ-001: Parameter n, default 32, total fixed-point word width in bits (signed two's complement).
REQ-002: Parameter d, default 16, number of fractional bits.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: recv_val  input  1  input operands valid.
REQ-006: recv_rdy  output  1  block can accept operands.
REQ-007: cr, cc  input  n each  real/imag of butterfly upper output c.
REQ-008: dr, dc  input  n each  real/imag of butterfly lower output d.
REQ-009: wr, wc  input  n each  real/imag of twiddle w (unit magnitude).
REQ-010: send_val  output  1  result outputs valid.
REQ-011: send_rdy  input  1  downstream accepts result.
REQ-012: ar, ac, br, bc  output  n each  recovered operands a and b, registered.

Function
REQ-013: Block SHALL invert c = a + w*b, d = a - w*b: a = (c+d)/2, b = (c-d)*conj(w)/2.
REQ-014: FSM states SHALL be IDLE, MUL, DONE; recv_rdy = 1 only in IDLE; send_val = 1 only in DONE.
REQ-015: IDLE, recv_val=1 at an edge -> latch sr=cr+dr, sc=cc+dc, er=cr-dr, ec=cc-dc, wr, wc; clear accumulators pr, pc; step counter to 0; enter MUL.
REQ-016: Sums/differences SHALL be n-bit with two's-complement wrap (no saturation).
REQ-017: MUL SHALL take exactly 4 edges, one product per edge via a single signed n x n multiplier: k=0 pr+=er*wr; k=1 pr+=ec*wc; k=2 pc+=ec*wr; k=3 pc-=er*wc.
REQ-018: Each product SHALL be the full 2n-bit signed product truncated to bits [n+d-1:d] (floor), accumulated n-bit with wrap.
REQ-019: On the k=3 edge: ar=sr>>>1, ac=sc>>>1, br=(pr after k=1)>>>1, bc=(pc incl. k=3 term)>>>1 (arithmetic shifts); enter DONE.
REQ-020: Latency: send_val SHALL be high in the 4th cycle after the accept edge (accept at edge E0, outputs registered at E4).
REQ-021: DONE, send_rdy=1 at an edge -> enter IDLE; recv_rdy high the following cycle; no overlap of consecutive operations.
REQ-022: DONE, send_rdy=0 -> hold; ar/ac/br/bc and send_val stable indefinitely.
REQ-023: recv_val while in MUL or DONE SHALL be ignored; latched operands unaffected by input changes after accept.
REQ-024: ar/ac/br/bc SHALL change only on the REQ-019 edge or reset.

Reset
REQ-025: reset=1 at an edge SHALL force IDLE, recv_rdy=1, send_val=0, ar=ac=br=bc=0, accumulators and counter 0.
REQ-026: Reset SHALL take priority over every handshake, including mid-MUL and in DONE; in-flight operation discarded, no send_val pulse.

Verification (n=32, d=16, 1.0=0x00010000)
REQ-027: c=(3.0,1.0), d=(1.0,-1.0), w=(1.0,0) -> a=(2.0,0), b=(1.0,1.0); send_val rises 4 cycles after accept.
REQ-028: c=(1.0,2.0), d=(1.0,0), w=(0,1.0) -> a=(1.0,1.0), b=(1.0,0).
REQ-029: c=(-1.0,0), d=(0,0), w=(1.0,0) -> a=(0xFFFF8000,0) i.e. -0.5, b=(-0.5,0) (arithmetic-shift sign check).
REQ-030: Result held with send_rdy=0 for 10 cycles -> outputs and send_val constant; recv_val pulses during hold ignored; send_rdy=1 -> recv_rdy=1 next cycle.
REQ-031: reset asserted 2 cycles after accept -> next cycle IDLE, all outputs 0, no send_val; new operation afterwards yields correct result.
REQ-032: Randomized a,b,w (|w|=1, small magnitudes) fed through a reference forward butterfly model -> recovered a,b within 2 LSB.

Source files
------------

// File: rtl/inv_butterfly.sv
// rtl/inv_butterfly.sv - inverse radix-2 butterfly: recovers a, b from c = a + w*b, d = a - w*b.
// Fixed-point signed n-bit words with d fractional bits; one shared multiplier, four products per op.
module inv_butterfly #(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] cr,
  input  logic [n-1:0] cc,
  input  logic [n-1:0] dr,
  input  logic [n-1:0] dc,
  input  logic [n-1:0] wr,
  input  logic [n-1:0] wc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] ar,
  output logic [n-1:0] ac,
  output logic [n-1:0] br,
  output logic [n-1:0] bc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic         accept;
  logic         finish;
  logic [1:0]   step;
  logic [n-1:0] sr;
  logic [n-1:0] sc;
  logic [n-1:0] er;
  logic [n-1:0] ec;
  logic [n-1:0] tw_r;
  logic [n-1:0] tw_c;
  logic [n-1:0] pr;
  logic [n-1:0] pc;
  logic [n-1:0] mul_x;
  logic [n-1:0] mul_y;
  logic signed [2*n-1:0] prod;
  logic [n-1:0] term;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    recv_rdy   = 1'b0;
    send_val   = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          accept     = 1'b1;
          state_next = MUL;
        end
      end
      MUL: begin
        if (step == 2'd3) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Product schedule: e*conj(w) = (er*wr + ec*wc) + j(ec*wr - er*wc).
  always_comb begin
    mul_x = er;
    mul_y = tw_c;
    case (step)
      2'd0: begin
        mul_x = er;
        mul_y = tw_r;
      end
      2'd1: begin
        mul_x = ec;
        mul_y = tw_c;
      end
      2'd2: begin
        mul_x = ec;
        mul_y = tw_r;
      end
      default: begin
        mul_x = er;
        mul_y = tw_c;
      end
    endcase
  end

  assign prod = $signed({{n{mul_x[n-1]}}, mul_x}) * $signed({{n{mul_y[n-1]}}, mul_y});
  // Arithmetic shift then truncate keeps bits [n+d-1:d], i.e. a floored fixed-point product.
  assign term = n'(prod >>> d);

  always_ff @(posedge clk) begin
    if (reset) begin
      step <= 2'd0;
      sr   <= '0;
      sc   <= '0;
      er   <= '0;
      ec   <= '0;
      tw_r <= '0;
      tw_c <= '0;
      pr   <= '0;
      pc   <= '0;
      ar   <= '0;
      ac   <= '0;
      br   <= '0;
      bc   <= '0;
    end else if (accept) begin
      sr   <= cr + dr;
      sc   <= cc + dc;
      er   <= cr - dr;
      ec   <= cc - dc;
      tw_r <= wr;
      tw_c <= wc;
      pr   <= '0;
      pc   <= '0;
      step <= 2'd0;
    end else if (state == MUL) begin
      step <= step + 2'd1;
      case (step)
        2'd0: pr <= pr + term;
        2'd1: pr <= pr + term;
        2'd2: pc <= pc + term;
        default: pc <= pc - term;
      endcase
      if (finish) begin
        ar <= $signed(sr) >>> 1;
        ac <= $signed(sc) >>> 1;
        br <= $signed(pr) >>> 1;
        bc <= $signed(pc - term) >>> 1;
      end
    end
  end

endmodule
